// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types for the data-memory arbiter (FSM states, read owner, request bundle)
package dmem_arb_pkg;
  localparam int DM_AW = 9;
  localparam int DW = 32;
  typedef enum logic {PRI_CPU, PRI_DBG} arb_state_e;
  typedef enum logic [1:0] {NONE, CPU, DBG} rd_owner_e;
  typedef struct packed {
    logic req;
    logic we;
    logic [DM_AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [2:0] funct3;
  } dmem_req_t;
endpackage

// File: rtl/arb_starve_ctr.sv
// arb_starve_ctr: saturating 4-bit count of consecutive denied DBG cycles
// ports: clk, reset (async, active-high), inc/clr controls, hit = count is one short of MAX
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);
  localparam logic [3:0] M = 4'(MAX);
  logic [3:0] sc;
  always_ff @(posedge clk or posedge reset)
    if (reset) sc <= '0;
    else sc <= clr ? '0 : (inc && sc != M) ? sc + 4'd1 : sc;
  assign hit = sc == M - 4'd1;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between CPU MEM stage and DBG master
// ports: clk, reset (async, active-high); cpu_*/dbg_* request payloads in, gnt/rvalid/rdata out;
//        mem_* drive datamemory, mem_rdata returns one cycle after mem_rd; stall feeds hazard unit
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = DM_AW,
  parameter int DATA_W = DW,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  input  logic [2:0]            dbg_funct3,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall
);
  arb_state_e state;
  rd_owner_e rd_owner;
  logic hit;
  dmem_req_t cpu_r, dbg_r, sel;
  assign cpu_r = '{cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3};
  assign dbg_r = '{dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_funct3};
  // grants are masked during reset so no memory enable escapes while reset is high
  assign cpu_gnt = !reset && cpu_req && (state == PRI_CPU || !dbg_req);
  assign dbg_gnt = !reset && dbg_req && (state == PRI_DBG || !cpu_req);
  assign sel = cpu_gnt ? cpu_r : dbg_gnt ? dbg_r : '0;
  assign mem_rd = sel.req && !sel.we;
  assign mem_wr = sel.req && sel.we;
  assign mem_addr = sel.addr;
  assign mem_wdata = sel.wdata;
  assign mem_funct3 = sel.funct3;
  assign stall = cpu_req && !cpu_gnt;
  assign cpu_rvalid = rd_owner == CPU;
  assign dbg_rvalid = rd_owner == DBG;
  assign cpu_rdata = cpu_rvalid ? mem_rdata : '0;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : '0;
  arb_starve_ctr #(.MAX(STARVE_MAX)) u_ctr (
    .clk(clk),
    .reset(reset),
    .inc(dbg_req && !dbg_gnt),
    .clr(dbg_gnt || !dbg_req),
    .hit(hit)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= PRI_CPU;
      rd_owner <= NONE;
    end else begin
      rd_owner <= !mem_rd ? NONE : cpu_gnt ? CPU : DBG;
      // a DBG denial on the last allowed cycle hands priority to DBG for one grant
      state <= state == PRI_CPU ? ((hit && dbg_req && !dbg_gnt) ? PRI_DBG : PRI_CPU)
                                : ((dbg_gnt || !dbg_req) ? PRI_CPU : PRI_DBG);
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors with a queue scoreboard checked by an independent monitor
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;
  typedef struct packed {
    logic cg, dg, st, rd, wr;
    logic [8:0] a;
    logic [31:0] wd;
    logic [2:0] f3;
    logic cv;
    logic [31:0] cd;
    logic dv;
    logic [31:0] dd;
  } out_t;
  logic clk = 0, reset = 0;
  logic cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [8:0] cpu_addr = 0, dbg_addr = 0, mem_addr;
  logic [31:0] cpu_wdata = 0, dbg_wdata = 0, mem_rdata = 0, cpu_rdata, dbg_rdata, mem_wdata;
  logic [2:0] cpu_funct3 = 0, dbg_funct3 = 0, mem_funct3;
  logic cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, mem_rd, mem_wr, stall;
  int n_pass = 0, n_tot = 0;
  out_t eq[$];
  string nq[$];
  always #5 clk = ~clk;
  dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_funct3(cpu_funct3), .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_funct3(dbg_funct3), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .stall(stall)
  );
  function automatic out_t o(input logic cg, dg, st, rd, wr, input logic [8:0] a,
                             input logic [31:0] wd, input logic [2:0] f3, input logic cv,
                             input logic [31:0] cd, input logic dv, input logic [31:0] dd);
    return {cg, dg, st, rd, wr, a, wd, f3, cv, cd, dv, dd};
  endfunction
  task automatic cyc(input string nm, input logic rs, input logic cr, cw, input logic [8:0] ca,
                     input logic [31:0] cwd, input logic [2:0] cf, input logic dr, dw,
                     input logic [8:0] da, input logic [31:0] dwd, input logic [2:0] df,
                     input logic [31:0] mr, input out_t e);
    @(posedge clk);
    #1;
    reset = rs;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cwd; cpu_funct3 = cf;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dwd; dbg_funct3 = df;
    mem_rdata = mr;
    eq.push_back(e);
    nq.push_back(nm);
  endtask
  task automatic idle(input string nm, input logic rs, input logic [31:0] mr, input out_t e);
    cyc(nm, rs, '0, '0, 9'h0, 32'h0, 3'd0, '0, '0, 9'h0, 32'h0, 3'd0, mr, e);
  endtask
  task automatic chk_int(input string nm, input arb_state_e s, input logic [3:0] sc);
    n_tot++;
    if (dut.state === s && dut.u_ctr.sc === sc) n_pass++;
    else $display("FAIL %s: got state=%0d sc=%0d want state=%0d sc=%0d", nm, dut.state, dut.u_ctr.sc, s, sc);
  endtask
  always @(negedge clk)
    if (eq.size() > 0) begin
      out_t e, a;
      string nm;
      e = eq.pop_front();
      nm = nq.pop_front();
      a = {cpu_gnt, dbg_gnt, stall, mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
           cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata};
      n_tot++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, a, e);
    end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    #2 reset = 1;
    cyc("reset_out", '1, '1, '0, 9'h010, 32'h0, 3'd2, '1, '1, 9'h020, 32'h11, 3'd2, 32'h55,
        o('0, '0, '1, '0, '0, 9'h0, 32'h0, 3'd0, '0, 32'h0, '0, 32'h0));
    cyc("cpu_rd_gnt", '0, '1, '0, 9'h010, 32'h0BADF00D, 3'd2, '0, '0, 9'h0, 32'h0, 3'd0, 32'h0,
        o('1, '0, '0, '1, '0, 9'h010, 32'h0BADF00D, 3'd2, '0, 32'h0, '0, 32'h0));
    idle("cpu_rd_data", '0, 32'hDEADBEEF, o('0, '0, '0, '0, '0, 9'h0, 32'h0, 3'd0, '1, 32'hDEADBEEF, '0, 32'h0));
    cyc("dbg_wr_gnt", '0, '0, '0, 9'h0, 32'h0, 3'd0, '1, '1, 9'h020, 32'h12345678, 3'd2, 32'h0,
        o('0, '1, '0, '0, '1, 9'h020, 32'h12345678, 3'd2, '0, 32'h0, '0, 32'h0));
    idle("dbg_wr_no_rv", '0, 32'hAAAA5555, o('0, '0, '0, '0, '0, 9'h0, 32'h0, 3'd0, '0, 32'h0, '0, 32'h0));
    for (int i = 0; i < 4; i++)
      cyc($sformatf("cont_cpu%0d", i), '0, '1, '0, 9'h030, 32'h0, 3'd2, '1, '0, 9'h040, 32'h0, 3'd0,
          32'h10000000 + i,
          o('1, '0, '0, '1, '0, 9'h030, 32'h0, 3'd2, i > 0, i > 0 ? 32'h10000000 + i : 32'h0, '0, 32'h0));
    cyc("cont_dbg_forced", '0, '1, '0, 9'h030, 32'h0, 3'd2, '1, '0, 9'h040, 32'h0, 3'd0, 32'h10000004,
        o('0, '1, '1, '1, '0, 9'h040, 32'h0, 3'd0, '1, 32'h10000004, '0, 32'h0));
    cyc("cont_cpu_again", '0, '1, '0, 9'h030, 32'h0, 3'd2, '1, '0, 9'h040, 32'h0, 3'd0, 32'h10000005,
        o('1, '0, '0, '1, '0, 9'h030, 32'h0, 3'd2, '0, 32'h0, '1, 32'h10000005));
    idle("cont_tail", '0, 32'h10000006, o('0, '0, '0, '0, '0, 9'h0, 32'h0, 3'd0, '1, 32'h10000006, '0, 32'h0));
    cyc("alt_cpu", '0, '1, '0, 9'h004, 32'h0, 3'd2, '0, '0, 9'h0, 32'h0, 3'd0, 32'h0,
        o('1, '0, '0, '1, '0, 9'h004, 32'h0, 3'd2, '0, 32'h0, '0, 32'h0));
    cyc("alt_dbg", '0, '0, '0, 9'h0, 32'h0, 3'd0, '1, '0, 9'h008, 32'h0, 3'd2, 32'h00000404,
        o('0, '1, '0, '1, '0, 9'h008, 32'h0, 3'd2, '1, 32'h00000404, '0, 32'h0));
    idle("alt_dbg_data", '0, 32'h00000808, o('0, '0, '0, '0, '0, 9'h0, 32'h0, 3'd0, '0, 32'h0, '1, 32'h00000808));
    for (int i = 0; i < 2; i++)
      cyc($sformatf("drop_both%0d", i), '0, '1, '0, 9'h050, 32'h0, 3'd2, '1, '0, 9'h060, 32'h0, 3'd2,
          32'h20000000 + i,
          o('1, '0, '0, '1, '0, 9'h050, 32'h0, 3'd2, i > 0, i > 0 ? 32'h20000000 + i : 32'h0, '0, 32'h0));
    cyc("drop_dbg_off", '0, '1, '0, 9'h050, 32'h0, 3'd2, '0, '0, 9'h0, 32'h0, 3'd0, 32'h20000002,
        o('1, '0, '0, '1, '0, 9'h050, 32'h0, 3'd2, '1, 32'h20000002, '0, 32'h0));
    for (int i = 3; i < 6; i++) begin
      cyc($sformatf("drop_again%0d", i), '0, '1, '0, 9'h050, 32'h0, 3'd2, '1, '0, 9'h060, 32'h0, 3'd2,
          32'h20000000 + i, o('1, '0, '0, '1, '0, 9'h050, 32'h0, 3'd2, '1, 32'h20000000 + i, '0, 32'h0));
      if (i == 3) chk_int("drop_sc_clear", PRI_CPU, 4'd0);
    end
    idle("drop_tail", '0, 32'h20000006, o('0, '0, '0, '0, '0, 9'h0, 32'h0, 3'd0, '1, 32'h20000006, '0, 32'h0));
    cyc("rst_pre_gnt", '0, '1, '0, 9'h070, 32'h0, 3'd2, '1, '0, 9'h080, 32'h0, 3'd2, 32'h0,
        o('1, '0, '0, '1, '0, 9'h070, 32'h0, 3'd2, '0, 32'h0, '0, 32'h0));
    cyc("rst_mid", '1, '1, '1, 9'h090, 32'h33, 3'd2, '0, '0, 9'h0, 32'h0, 3'd0, 32'hBADBAD00,
        o('0, '0, '1, '0, '0, 9'h0, 32'h0, 3'd0, '0, 32'h0, '0, 32'h0));
    idle("rst_release", '0, 32'h0, o('0, '0, '0, '0, '0, 9'h0, 32'h0, 3'd0, '0, 32'h0, '0, 32'h0));
    chk_int("rst_state_sc", PRI_CPU, 4'd0);
    cyc("post_rst_rd", '0, '1, '0, 9'h0A0, 32'h0, 3'd2, '0, '0, 9'h0, 32'h0, 3'd0, 32'h0,
        o('1, '0, '0, '1, '0, 9'h0A0, 32'h0, 3'd2, '0, 32'h0, '0, 32'h0));
    idle("post_rst_data", '0, 32'h0000CAFE, o('0, '0, '0, '0, '0, 9'h0, 32'h0, 3'd0, '1, 32'h0000CAFE, '0, 32'h0));
    @(negedge clk);
    @(negedge clk);
    if (eq.size() != 0) begin
      n_tot++;
      $display("FAIL drain: got %0d pending want 0", eq.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single data-memory port between the pipeline MEM stage (CPU) and a debug/loader master (DBG). It sits between the EX/MEM pipeline register outputs and `datamemory`. It also drives a stall request into hazard logic whenever the MEM-stage access is not granted. CPU has fixed priority, and a starvation counter guarantees DBG forward progress.

## Interface
Parameters:
- `DM_ADDRESS`, 9 — data-memory byte address width
- `DATA_W`, 32 — data width
- `STARVE_MAX`, 4 — number of consecutive denied DBG cycles that forces a DBG grant (1..15)

Ports:
- `clk` in 1 — single clock, rising edge
- `reset` in 1 — asynchronous, active-high
- `cpu_req` in 1 — CPU access request (MEM stage MemRead|MemWrite)
- `cpu_we` in 1 — 1 = write, 0 = read
- `cpu_addr` in DM_ADDRESS — byte address
- `cpu_wdata` in DATA_W — store data
- `cpu_funct3` in 3 — access size/sign, passed to memory
- `cpu_gnt` out 1 — CPU access issued this cycle
- `cpu_rvalid` out 1 — CPU read data valid
- `cpu_rdata` out DATA_W — CPU read data
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`, `dbg_funct3` in — same meaning, DBG master
- `dbg_gnt`, `dbg_rvalid`, `dbg_rdata` out — same meaning, DBG master
- `mem_rd` out 1 — memory read enable
- `mem_wr` out 1 — memory write enable
- `mem_addr` out DM_ADDRESS — memory address
- `mem_wdata` out DATA_W — memory write data
- `mem_funct3` out 3 — memory access size
- `mem_rdata` in DATA_W — memory read data, valid the cycle after `mem_rd`
- `stall` out 1 — `cpu_req && !cpu_gnt`, to hazard unit

## Operation
- FSM states: `PRI_CPU` (reset state), `PRI_DBG`.
- In `PRI_CPU`: `cpu_req` → `cpu_gnt`. Otherwise `dbg_req` → `dbg_gnt`.
- In `PRI_DBG`: `dbg_req` → `dbg_gnt`. Otherwise `cpu_req` → `cpu_gnt`.
- Grants are combinational from the current state and the requests. At most one grant is asserted per cycle.
- Starvation counter `sc` (4 bits):
  - Increments when `dbg_req && !dbg_gnt`.
  - Clears when `dbg_gnt` or `!dbg_req`.
  - Saturates at STARVE_MAX.
- State transitions:
  - `PRI_CPU` → `PRI_DBG` when `sc == STARVE_MAX-1` and DBG is denied this cycle.
  - `PRI_DBG` → `PRI_CPU` after any `dbg_gnt`, or when `dbg_req` drops.
- Memory-side signals:
  - `mem_*` payload is the granted requester's payload.
  - `mem_rd = gnt && !we`, `mem_wr = gnt && we`.
  - With no grant: `mem_rd = mem_wr = 0`, and address/data/funct3 = 0.
- Requester rules:
  - Hold `req` and payload stable until `gnt` is seen.
  - Deassert `req` or present the next access in the cycle after `gnt`.
  - Dropping `req` before `gnt` is legal; the access is abandoned.
- Read return:
  - Registered `rd_owner` (`NONE`/`CPU`/`DBG`) is set from the read grant.
  - The next cycle, the owner's `rvalid = 1` and its `rdata = mem_rdata`. The other requester's `rdata` = 0.
  - Writes produce no `rvalid`.
- Back-to-back reads from alternating owners are supported: one issue per cycle, returns in issue order.

## Timing
- Reset values: all `gnt`, `rvalid`, `mem_rd`, `mem_wr` = 0; `rdata`, `mem_addr`, `mem_wdata`, `mem_funct3` = 0; `stall` = `cpu_req` (combinational); state = `PRI_CPU`; `sc` = 0; `rd_owner` = `NONE`.
- Grant latency is 0 cycles when uncontended. Read data latency is 1 cycle after grant.
- Worst-case DBG wait is STARVE_MAX cycles. Worst-case CPU stall is 1 cycle per forced DBG grant.
- Simultaneous `cpu_req` and `dbg_req` with `sc < STARVE_MAX-1` in `PRI_CPU`: CPU is granted and `stall` = 0.
- Reset asserted mid-operation: any pending `rvalid` is suppressed, state and `sc` clear immediately (asynchronous), and no memory enable is driven while `reset` = 1.
- No combinational path from `mem_rdata` to any grant.

## Structure
- Shared package `dmem_arb_pkg`:
  - `arb_state_e` (`PRI_CPU`, `PRI_DBG`)
  - `rd_owner_e` (`NONE`, `CPU`, `DBG`)
  - `dmem_req_t` struct {`req`, `we`, `addr`, `wdata`, `funct3`}
- Sub-module `arb_starve_ctr`: saturating counter with `inc`/`clr` inputs and `hit` output.

## Test plan
- CPU-only: read `cpu_addr`=0x010 → same-cycle `cpu_gnt`=1, `mem_rd`=1, `mem_addr`=0x010; next cycle `cpu_rvalid`=1 and `cpu_rdata` equals `mem_rdata` (0xDEADBEEF).
- DBG-only: write `dbg_addr`=0x020, data 0x12345678, `funct3`=2 → `dbg_gnt`=1, `mem_wr`=1, no `rvalid`.
- Contention, STARVE_MAX=4, both requesting continuously → CPU granted cycles 0–3 with `stall`=0; cycle 4 DBG granted with `stall`=1; cycle 5 CPU granted again.
- Alternating reads (CPU 0x004 cycle n, DBG 0x008 cycle n+1) → `cpu_rvalid` at n+1, `dbg_rvalid` at n+2; each `rdata` is the correct word, the other requester's `rdata` = 0.
- DBG drops `req` at `sc`=2 → `sc` clears and state stays `PRI_CPU`.
- `reset` pulsed in the cycle after a CPU read grant → `cpu_rvalid` stays 0; after release, state = `PRI_CPU` and `sc` = 0.
